// File: rtl/mc_bus_slave_if.sv
// mc_bus_slave_if: MCU parallel memory bus pins plus the core-side FIFO,
// LA config and SRAM write hooks that the bus slave drives.
interface mc_bus_slave_if #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int FIFO_WIDTH    = 16
);

  // MCU side (strobes active low, all asynchronous to clock)
  logic                     mc_ce;
  logic                     mc_we;
  logic                     mc_oe;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_data_in;
  logic [MC_DATA_WIDTH-1:0] mc_data_out;
  logic                     mc_data_oe;

  // Core side: input FIFO word carries a command/data tag above the payload
  logic [FIFO_WIDTH:0]      fifo_in_data;
  logic                     fifo_in_push;
  logic                     fifo_in_full;
  logic [FIFO_WIDTH-1:0]    fifo_out_data;
  logic                     fifo_out_pop;
  logic                     fifo_out_nempty;
  logic [15:0]              la_config;
  logic [15:0]              sram_wdata;
  logic                     sram_wstrobe;

  modport slave (
    input  mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    input  fifo_in_full, fifo_out_data, fifo_out_nempty,
    output mc_data_out, mc_data_oe,
    output fifo_in_data, fifo_in_push, fifo_out_pop,
    output la_config, sram_wdata, sram_wstrobe
  );

  modport master (
    output mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    output fifo_in_full, fifo_out_data, fifo_out_nempty,
    input  mc_data_out, mc_data_oe,
    input  fifo_in_data, fifo_in_push, fifo_out_pop,
    input  la_config, sram_wdata, sram_wstrobe
  );

endinterface

// File: rtl/mc_bus_slave.sv
// mc_bus_slave: bridges the asynchronous MCU memory bus into the clock
// domain. Writes become tagged input-FIFO words, SRAM write requests or LA
// config updates; reads are served from the output FIFO, a status word or
// the config readback. All outputs are registered.
module mc_bus_slave #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int FIFO_WIDTH    = 16
) (
  input  logic          clock_i,
  input  logic          reset_i,
  mc_bus_slave_if.slave bus_io
);

  // Write-side register map
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_DATA   = MC_ADD_WIDTH'(0);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_CMD    = MC_ADD_WIDTH'(1);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_SRAM   = MC_ADD_WIDTH'(2);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_CONFIG = MC_ADD_WIDTH'(3);
  // Read-side register map
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_FIFO   = MC_ADD_WIDTH'(0);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_STATUS = MC_ADD_WIDTH'(1);

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRIVE = 1'b1
  } readState_t;

  // Strobe synchronisers and edge-detect copies
  logic ceMeta_q, ceSync_q;
  logic weMeta_q, weSync_q, wePrev_q;
  logic oeMeta_q, oeSync_q, oePrev_q;

  // Post-reset arming: a strobe must be seen high before it can act
  logic [1:0] settleCnt_q;
  logic       weArmed_q;
  logic       oeArmed_q;

  // Write capture
  logic                     writeValid_q;
  logic [MC_ADD_WIDTH-1:0]  wrAddr_q;
  logic [MC_DATA_WIDTH-1:0] wrData_q;

  // Read state
  readState_t               readState_q;
  logic [MC_ADD_WIDTH-1:0]  rdAddr_q;
  logic                     popPending_q;

  // Registered outputs
  logic [MC_DATA_WIDTH-1:0] dataOut_q;
  logic                     dataOe_q;
  logic [FIFO_WIDTH:0]      fifoInData_q;
  logic                     fifoInPush_q;
  logic                     fifoOutPop_q;
  logic [15:0]              laConfig_q;
  logic [15:0]              sramWdata_q;
  logic                     sramWstrobe_q;

  // Sticky error flags
  logic overrun_q, overrun_d;
  logic underrun_q, underrun_d;

  // Decoded events
  logic settled;
  logic captureEn;
  logic weRise;
  logic commit;
  logic oeFall;
  logic oeRise;
  logic readStart;
  logic readAbort;
  logic readEnd;
  logic isFifoWrite;
  logic setOverrun;
  logic setUnderrun;
  logic clearFlags;
  logic [MC_DATA_WIDTH-1:0] readMux;

  assign settled     = (settleCnt_q == 2'd2);
  assign captureEn   = weArmed_q & ~weSync_q & ~ceSync_q;
  assign weRise      = weSync_q & ~wePrev_q;
  assign commit      = weRise & writeValid_q;
  assign oeFall      = oeArmed_q & ~oeSync_q & oePrev_q;
  assign oeRise      = oeSync_q & ~oePrev_q;
  assign readStart   = (readState_q == RD_IDLE) & oeFall & ~ceSync_q & weSync_q;
  assign readAbort   = (readState_q == RD_DRIVE) & ~weSync_q;
  assign readEnd     = (readState_q == RD_DRIVE) & weSync_q & oeRise;
  assign isFifoWrite = (wrAddr_q == ADDR_DATA) | (wrAddr_q == ADDR_CMD);
  assign setOverrun  = commit & isFifoWrite & bus_io.fifo_in_full;
  assign setUnderrun = readStart & (bus_io.mc_add == ADDR_FIFO) & ~bus_io.fifo_out_nempty;
  assign clearFlags  = readEnd & (rdAddr_q == ADDR_STATUS);

  // Bring the raw strobes into the clock domain and keep a delayed copy for edges
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ceMeta_q <= 1'b1;
      ceSync_q <= 1'b1;
      weMeta_q <= 1'b1;
      weSync_q <= 1'b1;
      wePrev_q <= 1'b1;
      oeMeta_q <= 1'b1;
      oeSync_q <= 1'b1;
      oePrev_q <= 1'b1;
    end else begin
      ceMeta_q <= bus_io.mc_ce;
      ceSync_q <= ceMeta_q;
      weMeta_q <= bus_io.mc_we;
      weSync_q <= weMeta_q;
      wePrev_q <= weSync_q;
      oeMeta_q <= bus_io.mc_oe;
      oeSync_q <= oeMeta_q;
      oePrev_q <= oeSync_q;
    end
  end

  // Ignore strobes that were already low at reset until they have been seen high
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      settleCnt_q <= 2'd0;
      weArmed_q   <= 1'b0;
      oeArmed_q   <= 1'b0;
    end else begin
      if (!settled) begin
        settleCnt_q <= settleCnt_q + 2'd1;
      end
      if (settled && weSync_q) begin
        weArmed_q <= 1'b1;
      end
      if (settled && oeSync_q) begin
        oeArmed_q <= 1'b1;
      end
    end
  end

  // Capture address/data during the write strobe and commit on its rising edge
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      writeValid_q  <= 1'b0;
      wrAddr_q      <= '0;
      wrData_q      <= '0;
      fifoInData_q  <= '0;
      fifoInPush_q  <= 1'b0;
      sramWdata_q   <= '0;
      sramWstrobe_q <= 1'b0;
      laConfig_q    <= '0;
    end else begin
      fifoInPush_q  <= 1'b0;
      sramWstrobe_q <= 1'b0;
      if (captureEn) begin
        wrAddr_q     <= bus_io.mc_add;
        wrData_q     <= bus_io.mc_data_in;
        writeValid_q <= 1'b1;
      end else if (weRise) begin
        writeValid_q <= 1'b0;
      end
      if (commit) begin
        case (wrAddr_q)
          ADDR_DATA, ADDR_CMD: begin
            if (!bus_io.fifo_in_full) begin
              fifoInData_q <= {(wrAddr_q == ADDR_CMD), wrData_q[FIFO_WIDTH-1:0]};
              fifoInPush_q <= 1'b1;
            end
          end
          ADDR_SRAM: begin
            sramWdata_q   <= wrData_q;
            sramWstrobe_q <= 1'b1;
          end
          ADDR_CONFIG: begin
            laConfig_q <= wrData_q;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Select the word presented when a read begins
  always_comb begin
    readMux = '0;
    case (bus_io.mc_add)
      ADDR_FIFO: begin
        if (bus_io.fifo_out_nempty) begin
          readMux = bus_io.fifo_out_data;
        end
      end
      ADDR_STATUS: begin
        readMux = {{(MC_DATA_WIDTH-4){1'b0}}, overrun_q, underrun_q,
                   bus_io.fifo_in_full, bus_io.fifo_out_nempty};
      end
      ADDR_CONFIG: begin
        readMux = laConfig_q;
      end
      default: begin
        readMux = '0;
      end
    endcase
  end

  // Read sequencer: latch once on OE fall, drive until OE rise, abort if WE falls
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      readState_q  <= RD_IDLE;
      rdAddr_q     <= '0;
      popPending_q <= 1'b0;
      dataOut_q    <= '0;
      dataOe_q     <= 1'b0;
      fifoOutPop_q <= 1'b0;
    end else begin
      fifoOutPop_q <= 1'b0;
      case (readState_q)
        RD_IDLE: begin
          if (readStart) begin
            dataOut_q    <= readMux;
            dataOe_q     <= 1'b1;
            rdAddr_q     <= bus_io.mc_add;
            popPending_q <= (bus_io.mc_add == ADDR_FIFO) & bus_io.fifo_out_nempty;
            readState_q  <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (readAbort) begin
            dataOe_q     <= 1'b0;
            popPending_q <= 1'b0;
            readState_q  <= RD_IDLE;
          end else if (readEnd) begin
            dataOe_q     <= 1'b0;
            fifoOutPop_q <= popPending_q;
            popPending_q <= 1'b0;
            readState_q  <= RD_IDLE;
          end
        end
        default: begin
          readState_q <= RD_IDLE;
        end
      endcase
    end
  end

  // Status flags clear after a status read, but a simultaneous new error wins
  always_comb begin
    overrun_d  = (overrun_q & ~clearFlags) | setOverrun;
    underrun_d = (underrun_q & ~clearFlags) | setUnderrun;
  end

  // Hold the sticky error flags
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus_io.mc_data_out  = dataOut_q;
  assign bus_io.mc_data_oe   = dataOe_q;
  assign bus_io.fifo_in_data = fifoInData_q;
  assign bus_io.fifo_in_push = fifoInPush_q;
  assign bus_io.fifo_out_pop = fifoOutPop_q;
  assign bus_io.la_config    = laConfig_q;
  assign bus_io.sram_wdata   = sramWdata_q;
  assign bus_io.sram_wstrobe = sramWstrobe_q;

endmodule

// File: tb/tb_mc_bus_slave.sv
// tb_mc_bus_slave: table of bus transactions with fixed expectations, a few
// hand-written corner sequences, then random transactions scored against a
// transaction-level model of the slave's register map.
module tb_mc_bus_slave;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cycleCnt = 0;

  mc_bus_slave_if busIf ();

  mc_bus_slave dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus_io  (busIf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running cycle counter used to time output pulses
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Output monitor: every sampled high cycle of a pulse is logged
  logic [16:0] pushLog[$];
  logic [15:0] sramLog[$];
  int          popCount = 0;
  int          lastPushCycle = 0;
  int          lastPopCycle = 0;
  bit          oeEverHigh = 1'b0;

  always @(negedge clock) begin
    if (busIf.fifo_in_push === 1'b1) begin
      pushLog.push_back(busIf.fifo_in_data);
      lastPushCycle = cycleCnt;
    end
    if (busIf.sram_wstrobe === 1'b1) begin
      sramLog.push_back(busIf.sram_wdata);
    end
    if (busIf.fifo_out_pop === 1'b1) begin
      popCount++;
      lastPopCycle = cycleCnt;
    end
    if (busIf.mc_data_oe === 1'b1) begin
      oeEverHigh = 1'b1;
    end
  end

  typedef struct {
    bit          isWrite;
    logic [5:0]  addr;
    logic [15:0] data;
    bit          full;
    bit          nempty;
    logic [15:0] fifoOut;
    int          expPush;
    logic [16:0] expPushData;
    int          expSram;
    logic [15:0] expSramData;
    logic [15:0] expRead;
    int          expPop;
  } vector_t;

  vector_t vectors[16];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [5:0] addr, input logic [15:0] data,
                          output int riseCycle);
    @(negedge clock);
    busIf.mc_add     = addr;
    busIf.mc_data_in = data;
    busIf.mc_ce      = 1'b0;
    busIf.mc_we      = 1'b0;
    repeat (6) @(negedge clock);
    busIf.mc_we = 1'b1;
    riseCycle   = cycleCnt;
    @(negedge clock);
    busIf.mc_ce = 1'b1;
    repeat (7) @(negedge clock);
  endtask

  task automatic busRead(input logic [5:0] addr, output logic [15:0] data,
                         output logic oeHigh, output int riseCycle);
    @(negedge clock);
    busIf.mc_add = addr;
    busIf.mc_ce  = 1'b0;
    busIf.mc_oe  = 1'b0;
    repeat (6) @(negedge clock);
    data        = busIf.mc_data_out;
    oeHigh      = busIf.mc_data_oe;
    busIf.mc_oe = 1'b1;
    riseCycle   = cycleCnt;
    @(negedge clock);
    busIf.mc_ce = 1'b1;
    repeat (7) @(negedge clock);
  endtask

  task automatic applyStimulus(input vector_t v, input int idx);
    int          pushBefore;
    int          sramBefore;
    int          popBefore;
    int          rise;
    logic [15:0] rd;
    logic        oeHigh;
    string       tag;
    busIf.fifo_in_full    = v.full;
    busIf.fifo_out_nempty = v.nempty;
    busIf.fifo_out_data   = v.fifoOut;
    pushBefore = pushLog.size();
    sramBefore = sramLog.size();
    popBefore  = popCount;
    tag = $sformatf("vec%0d", idx);
    if (v.isWrite) begin
      busWrite(v.addr, v.data, rise);
      checkOutput({tag, ".pushCount"}, pushLog.size() - pushBefore, v.expPush);
      if (v.expPush == 1 && pushLog.size() > pushBefore) begin
        checkOutput({tag, ".pushData"}, pushLog[pushBefore], v.expPushData);
        checkOutput({tag, ".pushDelay"}, lastPushCycle - rise, 3);
      end
      checkOutput({tag, ".sramCount"}, sramLog.size() - sramBefore, v.expSram);
      if (v.expSram == 1 && sramLog.size() > sramBefore) begin
        checkOutput({tag, ".sramData"}, sramLog[sramBefore], v.expSramData);
      end
    end else begin
      busRead(v.addr, rd, oeHigh, rise);
      checkOutput({tag, ".readData"}, rd, v.expRead);
      checkOutput({tag, ".dataOe"}, oeHigh, 1);
      checkOutput({tag, ".popCount"}, popCount - popBefore, v.expPop);
      if (v.expPop == 1 && popCount > popBefore) begin
        checkOutput({tag, ".popDelayOk"},
                    (lastPopCycle - rise >= 1) && (lastPopCycle - rise <= 4), 1);
      end
    end
  endtask

  // Transaction-level model state for the random phase
  logic [15:0] mLaCfg;
  bit          mOverrun;
  bit          mUnderrun;

  int          pushBefore;
  int          sramBefore;
  int          popBefore;
  int          rise;
  logic [15:0] rd;
  logic        oeHigh;
  bit          rIsWrite;
  logic [5:0]  rAddr;
  logic [15:0] rData;
  bit          rFull;
  bit          rNempty;
  logic [15:0] rFifoOut;
  int          expPushN;
  logic [16:0] expWord;
  int          expSramN;
  int          expPopN;
  logic [15:0] expRead;

  initial begin
    busIf.mc_ce           = 1'b1;
    busIf.mc_we           = 1'b1;
    busIf.mc_oe           = 1'b1;
    busIf.mc_add          = '0;
    busIf.mc_data_in      = '0;
    busIf.fifo_in_full    = 1'b0;
    busIf.fifo_out_nempty = 1'b0;
    busIf.fifo_out_data   = '0;
    reset = 1'b1;
    repeat (4) @(negedge clock);

    checkOutput("rst.mc_data_out", busIf.mc_data_out, 16'h0000);
    checkOutput("rst.mc_data_oe", busIf.mc_data_oe, 0);
    checkOutput("rst.fifo_in_push", busIf.fifo_in_push, 0);
    checkOutput("rst.fifo_out_pop", busIf.fifo_out_pop, 0);
    checkOutput("rst.la_config", busIf.la_config, 16'h0000);
    checkOutput("rst.sram_wdata", busIf.sram_wdata, 16'h0000);
    checkOutput("rst.sram_wstrobe", busIf.sram_wstrobe, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    //                 wr  addr   data      full ne fifoOut   push word       sram data      read      pop
    vectors[0]  = '{1'b0, 6'h01, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[1]  = '{1'b1, 6'h01, 16'h0003, 1'b0, 1'b0, 16'h0000, 1, 17'h10003, 0, 16'h0000, 16'h0000, 0};
    vectors[2]  = '{1'b1, 6'h00, 16'h00FF, 1'b1, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[3]  = '{1'b0, 6'h01, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0008, 0};
    vectors[4]  = '{1'b0, 6'h01, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[5]  = '{1'b1, 6'h03, 16'h0009, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[6]  = '{1'b0, 6'h03, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0009, 0};
    vectors[7]  = '{1'b1, 6'h02, 16'h55AA, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 1, 16'h55AA, 16'h0000, 0};
    vectors[8]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 0, 17'h00000, 0, 16'h0000, 16'hBEEF, 1};
    vectors[9]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[10] = '{1'b0, 6'h01, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0004, 0};
    vectors[11] = '{1'b0, 6'h01, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[12] = '{1'b1, 6'h05, 16'h7777, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[13] = '{1'b0, 6'h07, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 17'h00000, 0, 16'h0000, 16'h0000, 0};
    vectors[14] = '{1'b0, 6'h01, 16'h0000, 1'b1, 1'b1, 16'h1357, 0, 17'h00000, 0, 16'h0000, 16'h0003, 0};
    vectors[15] = '{1'b1, 6'h00, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1, 17'h0ABCD, 0, 16'h0000, 16'h0000, 0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vectors[i], i);
    end

    // WE and OE low together: only the write may happen
    busIf.fifo_in_full    = 1'b0;
    busIf.fifo_out_nempty = 1'b0;
    pushBefore = pushLog.size();
    @(negedge clock);
    oeEverHigh       = 1'b0;
    busIf.mc_add     = 6'h00;
    busIf.mc_data_in = 16'h1234;
    busIf.mc_ce      = 1'b0;
    busIf.mc_we      = 1'b0;
    busIf.mc_oe      = 1'b0;
    repeat (6) @(negedge clock);
    busIf.mc_we = 1'b1;
    busIf.mc_oe = 1'b1;
    @(negedge clock);
    busIf.mc_ce = 1'b1;
    repeat (7) @(negedge clock);
    checkOutput("both.pushCount", pushLog.size() - pushBefore, 1);
    if (pushLog.size() > pushBefore) begin
      checkOutput("both.pushData", pushLog[pushBefore], 17'h01234);
    end
    checkOutput("both.oeNeverHigh", oeEverHigh, 0);
    busRead(6'h01, rd, oeHigh, rise);
    checkOutput("both.statusAfter", rd, 16'h0000);

    // Read in progress is cut short by a write
    busIf.fifo_out_nempty = 1'b1;
    busIf.fifo_out_data   = 16'h2222;
    pushBefore = pushLog.size();
    popBefore  = popCount;
    @(negedge clock);
    busIf.mc_add = 6'h00;
    busIf.mc_ce  = 1'b0;
    busIf.mc_oe  = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("abort.readData", busIf.mc_data_out, 16'h2222);
    checkOutput("abort.oeBefore", busIf.mc_data_oe, 1);
    busIf.mc_data_in = 16'h3333;
    busIf.mc_we      = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("abort.oeAfterWe", busIf.mc_data_oe, 0);
    busIf.mc_we = 1'b1;
    repeat (2) @(negedge clock);
    busIf.mc_oe = 1'b1;
    repeat (8) @(negedge clock);
    busIf.mc_ce = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("abort.popCount", popCount - popBefore, 0);
    checkOutput("abort.pushCount", pushLog.size() - pushBefore, 1);
    if (pushLog.size() > pushBefore) begin
      checkOutput("abort.pushData", pushLog[pushBefore], 17'h03333);
    end

    // Reset while WE is low: the held strobe must be ignored afterwards
    busIf.fifo_out_nempty = 1'b0;
    pushBefore = pushLog.size();
    @(negedge clock);
    busIf.mc_add     = 6'h00;
    busIf.mc_data_in = 16'h4321;
    busIf.mc_ce      = 1'b0;
    busIf.mc_we      = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("midrst.la_config", busIf.la_config, 16'h0000);
    checkOutput("midrst.mc_data_oe", busIf.mc_data_oe, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    busIf.mc_we = 1'b1;
    repeat (8) @(negedge clock);
    busIf.mc_ce = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("midrst.noPush", pushLog.size() - pushBefore, 0);
    pushBefore = pushLog.size();
    busWrite(6'h00, 16'h1111, rise);
    checkOutput("midrst.nextPushCount", pushLog.size() - pushBefore, 1);
    if (pushLog.size() > pushBefore) begin
      checkOutput("midrst.nextPushData", pushLog[pushBefore], 17'h01111);
      checkOutput("midrst.nextPushDelay", lastPushCycle - rise, 3);
    end

    // Random transactions against the register-map model
    $display("[TB] starting random transactions");
    mLaCfg    = 16'h0000;
    mOverrun  = 1'b0;
    mUnderrun = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rIsWrite = ($urandom_range(0, 1) == 1);
      rAddr    = 6'($urandom_range(0, 5));
      rData    = 16'($urandom);
      rFull    = ($urandom_range(0, 2) == 0);
      rNempty  = ($urandom_range(0, 1) == 1);
      rFifoOut = 16'($urandom);
      busIf.fifo_in_full    = rFull;
      busIf.fifo_out_nempty = rNempty;
      busIf.fifo_out_data   = rFifoOut;
      pushBefore = pushLog.size();
      sramBefore = sramLog.size();
      popBefore  = popCount;
      expPushN = 0;
      expSramN = 0;
      expPopN  = 0;
      expWord  = '0;
      expRead  = '0;
      if (rIsWrite) begin
        if (rAddr == 6'd0 || rAddr == 6'd1) begin
          if (rFull) mOverrun = 1'b1;
          else begin
            expPushN = 1;
            expWord  = {rAddr[0], rData};
          end
        end else if (rAddr == 6'd2) begin
          expSramN = 1;
        end else if (rAddr == 6'd3) begin
          mLaCfg = rData;
        end
        busWrite(rAddr, rData, rise);
        checkOutput($sformatf("rnd%0d.pushCount", t), pushLog.size() - pushBefore, expPushN);
        if (expPushN == 1 && pushLog.size() > pushBefore) begin
          checkOutput($sformatf("rnd%0d.pushData", t), pushLog[pushBefore], expWord);
        end
        checkOutput($sformatf("rnd%0d.sramCount", t), sramLog.size() - sramBefore, expSramN);
        if (expSramN == 1 && sramLog.size() > sramBefore) begin
          checkOutput($sformatf("rnd%0d.sramData", t), sramLog[sramBefore], rData);
        end
        checkOutput($sformatf("rnd%0d.la_config", t), busIf.la_config, mLaCfg);
      end else begin
        case (rAddr)
          6'd0: begin
            if (rNempty) begin
              expRead = rFifoOut;
              expPopN = 1;
            end else begin
              mUnderrun = 1'b1;
            end
          end
          6'd1: begin
            expRead   = {12'h000, mOverrun, mUnderrun, rFull, rNempty};
            mOverrun  = 1'b0;
            mUnderrun = 1'b0;
          end
          6'd3: expRead = mLaCfg;
          default: expRead = 16'h0000;
        endcase
        busRead(rAddr, rd, oeHigh, rise);
        checkOutput($sformatf("rnd%0d.readData", t), rd, expRead);
        checkOutput($sformatf("rnd%0d.dataOe", t), oeHigh, 1);
        checkOutput($sformatf("rnd%0d.popCount", t), popCount - popBefore, expPopN);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_bus_slave.md
Name: mc_bus_slave

Overview:
- Slave interface between the MCU parallel memory bus (mc_ce/mc_we/mc_oe, 6-bit address, 16-bit data) and the Bus Pirate core.
- Synchronises the asynchronous strobes into the clock domain.
- Commits writes as tagged words into the state-machine input FIFO, the LA config register, or the SRAM write path.
- Serves reads from the output FIFO, the status register and the config readback.

Parameters:
MC_DATA_WIDTH, 16, MCU data bus width
MC_ADD_WIDTH, 6, MCU address bus width
FIFO_WIDTH, 16, payload width of in/out FIFOs (input FIFO word is FIFO_WIDTH+1 with tag)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
mc_ce  in  1  chip enable, active low, async
mc_we  in  1  write strobe, active low, async
mc_oe  in  1  read strobe, active low, async
mc_add  in  MC_ADD_WIDTH  address, async
mc_data_in  in  MC_DATA_WIDTH  data from pad buffer
mc_data_out  out  MC_DATA_WIDTH  read data to pad buffer
mc_data_oe  out  1  high = drive mc_data pads
fifo_in_data  out  FIFO_WIDTH+1  {tag,payload}; tag 1 = command, 0 = data
fifo_in_push  out  1  one-cycle push
fifo_in_full  in  1  input FIFO full
fifo_out_data  in  FIFO_WIDTH  head of output FIFO
fifo_out_pop  out  1  one-cycle pop
fifo_out_nempty  in  1  output FIFO not empty
la_config  out  16  LA/SRAM mode register
sram_wdata  out  16  QPI write word
sram_wstrobe  out  1  one-cycle SRAM write request

Behaviour:
- Reset values:
  - Strobe synchronisers all 1.
  - mc_data_out=0, mc_data_oe=0, fifo_in_push=0, fifo_out_pop=0.
  - la_config=0, sram_wdata=0, sram_wstrobe=0.
  - overrun=0, underrun=0.
- Reset mid-access aborts it; a strobe still low after reset is ignored until it returns high (edge detector reset to "high").
- Strobes: 2-FF synchroniser on ce, we, oe, then a registered copy for edge detection.
- Address and data are captured every cycle while synced we=0 and ce=0. Value at the last such cycle is used.
- Write commit on synced we rising edge if captured ce=0. Actions occur 3 clocks after raw we rises; every pulse is exactly 1 cycle.
  - addr 0x00: push {0,data}.
  - addr 0x01: push {1,data}.
  - addr 0x02: sram_wdata<=data, sram_wstrobe pulse.
  - addr 0x03: la_config<=data.
  - other addresses: ignored.
- Push when fifo_in_full=1: word dropped, no push, sticky overrun<=1.
- Read: on synced oe falling with ce=0 and we high, latch mc_data_out once and set mc_data_oe=1 until synced oe rises.
  - addr 0x00: fifo_out_data if nempty, else 0x0000 and underrun<=1.
  - addr 0x01: status = {12'b0, overrun, underrun, fifo_in_full, fifo_out_nempty}.
  - addr 0x03: la_config.
  - other addresses: 0x0000.
- Read side effects on synced oe rising edge:
  - addr 0x00 and nempty was 1 at latch: fifo_out_pop for 1 cycle.
  - addr 0x01: overrun and underrun cleared, unless one is set in the same cycle, in which case the set wins.
- Simultaneous synced we=0 and oe=0: write has priority; read is not started, mc_data_oe stays 0.
- A read already in progress when we falls is terminated (mc_data_oe=0, no pop).
- Minimum strobe low time is 3 clocks; shorter pulses may be missed.

Test Plan:
- Reset, then WE pulse (6 clk low) addr 0x01 data 0x0003 -> fifo_in_data=0x1_0003, push high exactly 1 cycle, 3 clk after WE rise.
- WE addr 0x00 data 0x00FF with fifo_in_full=1 -> no push. Read addr 0x01 returns bit3=1; second read returns bit3=0.
- WE addr 0x03 data 0x0009, then OE addr 0x03 -> mc_data_out=0x0009 while mc_data_oe=1. WE addr 0x02 data 0x55AA -> sram_wdata=0x55AA, sram_wstrobe 1 cycle.
- Output FIFO holds 0xBEEF, OE addr 0x00 -> reads 0xBEEF, fifo_out_pop 1 cycle after OE rise. With nempty=0 -> reads 0x0000, no pop, status bit2=1.
- WE and OE low together, addr 0x00 data 0x1234 -> only push {0,0x1234}, mc_data_oe never high.
- Assert reset while WE low -> no push after reset even when WE rises; next full WE pulse commits normally.
